frog_mover_n: RTL and testbench

- Parametrised successor to the single-frog mover. Converts keyboard keycodes into grid hops on the frame clock, clamped to the playfield.
- Adds carry-drift from an arbitrary number of moving platform channels, a hop-animation window, a facing output and an edge-hit pulse.
- Sits between the keycode decoder / collision logic and the sprite renderer. One instance per player.

---
 rtl/frog_mover_n.sv | 188 ++++++++++++++++++
 tb/tb_frog_mover_n.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frog_mover_n.sv
// Keycode-driven grid mover for one frog: clamped hops, platform carry-drift,
// hop-animation window, facing and edge-hit pulse, all registered on frame_clk.
module frog_mover_n #(
    parameter int unsigned X_CENTER   = 296,
    parameter int unsigned Y_CENTER   = 335,
    parameter int unsigned X_MIN      = 0,
    parameter int unsigned X_MAX      = 627,
    parameter int unsigned Y_MIN      = 0,
    parameter int unsigned Y_MAX_HOP  = 348,
    parameter int unsigned X_STEP     = 12,
    parameter int unsigned Y_STEP     = 19,
    parameter int unsigned N_PLAT     = 4,
    parameter int unsigned DRIFT      = 1,
    parameter int unsigned HOP_FRAMES = 4,
    parameter logic [15:0] KEY_RIGHT  = 16'h004F,
    parameter logic [15:0] KEY_LEFT   = 16'h0050,
    parameter logic [15:0] KEY_DOWN   = 16'h0051,
    parameter logic [15:0] KEY_UP     = 16'h0052
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic [15:0]       keycode,
    input  logic              frogreset,
    input  logic              move_en,
    input  logic [2:0]        lives,
    input  logic [N_PLAT-1:0] on_platform,
    input  logic [N_PLAT-1:0] plat_moved,
    input  logic [N_PLAT-1:0] plat_dir,
    output logic [9:0]        FrogX,
    output logic [9:0]        FrogY,
    output logic [1:0]        facing,
    output logic              hopping,
    output logic              edge_hit
);

    typedef enum logic [1:0] {StIdle, StWaitRelease, StDead} state_e;

    localparam logic signed [11:0] XMin   = 12'(X_MIN);
    localparam logic signed [11:0] XMax   = 12'(X_MAX);
    localparam logic signed [11:0] YMin   = 12'(Y_MIN);
    localparam logic signed [11:0] YMax   = 12'(Y_MAX_HOP);
    localparam logic signed [11:0] XStep  = 12'(X_STEP);
    localparam logic signed [11:0] YStep  = 12'(Y_STEP);
    localparam logic signed [11:0] Drift  = 12'(DRIFT);

    state_e      r_state, w_state_nxt;
    logic [9:0]  r_x, r_y, w_x_nxt, w_y_nxt;
    logic [1:0]  r_facing, w_facing_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_hopping, w_hopping_nxt;
    logic        r_edge, w_edge_nxt;

    logic               w_found;
    logic signed [11:0] w_drift;
    logic               w_key_hit, w_hop_ok, w_move;
    logic [1:0]         w_key_face;
    logic signed [11:0] w_dx, w_dy;
    logic signed [11:0] w_x_ext, w_y_ext, w_sum_x, w_sum_y, w_clamp_x, w_clamp_y;

    // Lowest-index platform that both carries the frog and moved this frame wins.
    always_comb begin
        w_found = 1'b0;
        w_drift = '0;
        for (int i = 0; i < int'(N_PLAT); i++) begin
            if (!w_found && on_platform[i] && plat_moved[i]) begin
                w_found = 1'b1;
                w_drift = plat_dir[i] ? Drift : -Drift;
            end
        end
    end

    assign w_x_ext = $signed({2'b00, r_x});
    assign w_y_ext = $signed({2'b00, r_y});

    always_comb begin
        w_key_hit  = 1'b0;
        w_hop_ok   = 1'b0;
        w_key_face = 2'd0;
        w_dx       = '0;
        w_dy       = '0;
        case (keycode)
            KEY_RIGHT: begin
                w_key_hit  = 1'b1;
                w_hop_ok   = 1'b1;
                w_key_face = 2'd1;
                w_dx       = XStep;
            end
            KEY_LEFT: begin
                w_key_hit  = 1'b1;
                w_hop_ok   = 1'b1;
                w_key_face = 2'd3;
                w_dx       = -XStep;
            end
            KEY_DOWN: begin
                w_key_hit  = 1'b1;
                w_hop_ok   = (w_y_ext + YStep) <= YMax;
                w_key_face = 2'd2;
                w_dy       = YStep;
            end
            KEY_UP: begin
                w_key_hit  = 1'b1;
                w_hop_ok   = w_y_ext >= (YMin + YStep);
                w_key_face = 2'd0;
                w_dy       = -YStep;
            end
            default: ;
        endcase
    end

    assign w_move  = (r_state == StIdle) && w_key_hit && w_hop_ok;
    assign w_sum_x = w_x_ext + (w_move ? w_dx : 12'sd0) + w_drift;
    assign w_sum_y = w_y_ext + (w_move ? w_dy : 12'sd0);

    always_comb begin
        w_clamp_x = w_sum_x;
        if (w_sum_x < XMin) w_clamp_x = XMin;
        else if (w_sum_x > XMax) w_clamp_x = XMax;
        w_clamp_y = w_sum_y;
        if (w_sum_y < YMin) w_clamp_y = YMin;
        else if (w_sum_y > YMax) w_clamp_y = YMax;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_facing_nxt  = r_facing;
        w_cnt_nxt     = r_cnt;
        w_hopping_nxt = 1'b0;
        w_edge_nxt    = 1'b0;
        if (frogreset) begin
            w_x_nxt      = 10'(X_CENTER);
            w_y_nxt      = 10'(Y_CENTER);
            w_facing_nxt = 2'd0;
            w_cnt_nxt    = '0;
            w_state_nxt  = StWaitRelease;
        end else if (lives == 3'd0) begin
            w_state_nxt = StDead;
            w_cnt_nxt   = '0;
        end else if (move_en) begin
            case (r_state)
                StIdle, StWaitRelease: begin
                    w_x_nxt    = w_clamp_x[9:0];
                    w_y_nxt    = w_clamp_y[9:0];
                    w_edge_nxt = (w_clamp_x != w_sum_x) || (w_clamp_y != w_sum_y);
                    w_cnt_nxt  = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
                    if (r_state == StIdle && w_key_hit) begin
                        w_facing_nxt = w_key_face;
                        w_state_nxt  = StWaitRelease;
                        if (w_hop_ok) w_cnt_nxt = 4'(HOP_FRAMES);
                    end
                    if (r_state == StWaitRelease && keycode == 16'h0000) begin
                        w_state_nxt = StIdle;
                    end
                    w_hopping_nxt = (w_cnt_nxt != 4'd0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= StIdle;
            r_x       <= 10'(X_CENTER);
            r_y       <= 10'(Y_CENTER);
            r_facing  <= 2'd0;
            r_cnt     <= 4'd0;
            r_hopping <= 1'b0;
            r_edge    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_facing  <= w_facing_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hopping <= w_hopping_nxt;
            r_edge    <= w_edge_nxt;
        end
    end

    assign FrogX    = r_x;
    assign FrogY    = r_y;
    assign facing   = r_facing;
    assign hopping  = r_hopping;
    assign edge_hit = r_edge;

endmodule

// File: tb/tb_frog_mover_n.sv
// Bench for frog_mover_n: directed vector table, hand sequences for clamp/drift/reset
// corners, then randomized frames against a behavioural model.
module tb_frog_mover_n;

    localparam int NP = 4;

    logic          frame_clk = 1'b0;
    logic          Reset;
    logic [15:0]   keycode;
    logic          frogreset;
    logic          move_en;
    logic [2:0]    lives;
    logic [NP-1:0] on_platform, plat_moved, plat_dir;
    logic [9:0]    FrogX, FrogY;
    logic [1:0]    facing;
    logic          hopping, edge_hit;

    int n_checks = 0;
    int n_fail   = 0;

    frog_mover_n #(.N_PLAT(NP)) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .frogreset  (frogreset),
        .move_en    (move_en),
        .lives      (lives),
        .on_platform(on_platform),
        .plat_moved (plat_moved),
        .plat_dir   (plat_dir),
        .FrogX      (FrogX),
        .FrogY      (FrogY),
        .facing     (facing),
        .hopping    (hopping),
        .edge_hit   (edge_hit)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [15:0] key;
        logic        rst;
        logic        en;
        logic [2:0]  lv;
        int          x;
        int          y;
        int          f;
        int          h;
        int          e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int x, input int y, input int f,
                           input int h, input int e);
        chk({tag, ".x"}, 32'(FrogX), x);
        chk({tag, ".y"}, 32'(FrogY), y);
        chk({tag, ".facing"}, 32'(facing), f);
        chk({tag, ".hopping"}, 32'(hopping), h);
        chk({tag, ".edge"}, 32'(edge_hit), e);
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic set_in(input logic [15:0] k, input logic r, input logic en,
                          input logic [2:0] lv);
        keycode   = k;
        frogreset = r;
        move_en   = en;
        lives     = lv;
    endtask

    task automatic set_plat(input logic [NP-1:0] onp, input logic [NP-1:0] mv,
                            input logic [NP-1:0] dir);
        on_platform = onp;
        plat_moved  = mv;
        plat_dir    = dir;
    endtask

    // Behavioural model: position as plain integers, "waiting for release" and
    // "dead" as flags, hop window as a frame countdown.
    int m_x, m_y, m_face, m_cnt;
    bit m_wait, m_dead, m_hop, m_edge;

    task automatic model_reset();
        m_x = 296; m_y = 335; m_face = 0; m_cnt = 0;
        m_wait = 0; m_dead = 0; m_hop = 0; m_edge = 0;
    endtask

    task automatic model_frame();
        int drift, dx, dy, sx, sy, cx, cy;
        bit found, was_wait;
        m_hop = 0;
        m_edge = 0;
        if (frogreset) begin
            m_x = 296; m_y = 335; m_face = 0; m_cnt = 0; m_wait = 1; m_dead = 0;
        end else if (lives == 0) begin
            m_dead = 1;
            m_cnt  = 0;
        end else if (move_en && !m_dead) begin
            drift = 0;
            found = 0;
            for (int i = 0; i < NP; i++) begin
                if (!found && on_platform[i] && plat_moved[i]) begin
                    found = 1;
                    drift = plat_dir[i] ? 1 : -1;
                end
            end
            dx = 0;
            dy = 0;
            was_wait = m_wait;
            m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
            if (!was_wait) begin
                if (keycode == 16'h004F) begin m_face = 1; dx = 12; m_wait = 1; m_cnt = 4; end
                if (keycode == 16'h0050) begin m_face = 3; dx = -12; m_wait = 1; m_cnt = 4; end
                if (keycode == 16'h0051) begin
                    m_face = 2; m_wait = 1;
                    if (m_y + 19 <= 348) begin dy = 19; m_cnt = 4; end
                end
                if (keycode == 16'h0052) begin
                    m_face = 0; m_wait = 1;
                    if (m_y >= 19) begin dy = -19; m_cnt = 4; end
                end
            end else if (keycode == 0) begin
                m_wait = 0;
            end
            sx = m_x + dx + drift;
            sy = m_y + dy;
            cx = (sx < 0) ? 0 : (sx > 627) ? 627 : sx;
            cy = (sy < 0) ? 0 : (sy > 348) ? 348 : sy;
            m_edge = (cx != sx) || (cy != sy);
            m_x = cx;
            m_y = cy;
            m_hop = (m_cnt != 0);
        end
    endtask

    vec_t tbl[$];

    initial begin
        // Directed table, starting from IDLE at centre after reset.
        tbl.push_back('{16'h0000, 0, 1, 3, 296, 335, 0, 0, 0});
        tbl.push_back('{16'h004F, 0, 1, 3, 308, 335, 1, 1, 0});
        tbl.push_back('{16'h004F, 0, 1, 3, 308, 335, 1, 1, 0});
        tbl.push_back('{16'h004F, 0, 1, 3, 308, 335, 1, 1, 0});
        tbl.push_back('{16'h0000, 0, 1, 3, 308, 335, 1, 1, 0});
        tbl.push_back('{16'h0000, 0, 1, 3, 308, 335, 1, 0, 0});
        tbl.push_back('{16'h0051, 0, 1, 3, 308, 335, 2, 0, 0});
        tbl.push_back('{16'h0000, 0, 1, 3, 308, 335, 2, 0, 0});
        tbl.push_back('{16'h0052, 0, 1, 3, 308, 316, 0, 1, 0});
        tbl.push_back('{16'h0052, 0, 1, 3, 308, 316, 0, 1, 0});
        tbl.push_back('{16'h0000, 0, 1, 3, 308, 316, 0, 1, 0});
        tbl.push_back('{16'h004F, 0, 0, 3, 308, 316, 0, 0, 0});
        tbl.push_back('{16'h0000, 0, 1, 3, 308, 316, 0, 1, 0});
        tbl.push_back('{16'h0000, 0, 1, 3, 308, 316, 0, 0, 0});
        tbl.push_back('{16'h004F, 0, 1, 0, 308, 316, 0, 0, 0});
        tbl.push_back('{16'h004F, 0, 1, 0, 308, 316, 0, 0, 0});
        tbl.push_back('{16'h004F, 0, 1, 3, 308, 316, 0, 0, 0});
        tbl.push_back('{16'h004F, 1, 1, 3, 296, 335, 0, 0, 0});
        tbl.push_back('{16'h004F, 0, 1, 3, 296, 335, 0, 0, 0});
        tbl.push_back('{16'h0000, 0, 1, 3, 296, 335, 0, 0, 0});
        tbl.push_back('{16'h004F, 0, 1, 3, 308, 335, 1, 1, 0});
        tbl.push_back('{16'h0000, 0, 1, 3, 308, 335, 1, 1, 0});
        tbl.push_back('{16'h0000, 1, 1, 0, 296, 335, 0, 0, 0});
        tbl.push_back('{16'h0000, 0, 1, 0, 296, 335, 0, 0, 0});
        tbl.push_back('{16'h0000, 1, 1, 3, 296, 335, 0, 0, 0});
        tbl.push_back('{16'h0000, 0, 1, 3, 296, 335, 0, 0, 0});
        tbl.push_back('{16'h0004, 0, 1, 3, 296, 335, 0, 0, 0});
        tbl.push_back('{16'h0050, 0, 1, 3, 284, 335, 3, 1, 0});
        tbl.push_back('{16'h0000, 0, 1, 3, 284, 335, 3, 1, 0});

        Reset = 1'b0;
        set_in(16'h0000, 1'b0, 1'b1, 3'd3);
        set_plat('0, '0, '0);
        step();
        step();
        chk_all("reset", 296, 335, 0, 0, 0);
        Reset = 1'b1;

        foreach (tbl[i]) begin
            set_in(tbl[i].key, tbl[i].rst, tbl[i].en, tbl[i].lv);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].f, tbl[i].h, tbl[i].e);
        end

        // Channel 1 wins over channel 2 and carries left one pixel per frame.
        set_in(16'h0000, 1'b1, 1'b1, 3'd3);
        step();
        chk_all("drift.respawn", 296, 335, 0, 0, 0);
        frogreset = 1'b0;
        set_plat(4'b0110, 4'b0110, 4'b0100);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("drift.x", 32'(FrogX), 296 - i);
        end
        chk("drift.edge", 32'(edge_hit), 0);

        // Drift down to X = 5, then clamp at the left edge.
        for (int i = 0; i < 281; i++) step();
        chk("leftwalk.x", 32'(FrogX), 5);
        set_plat('0, '0, '0);
        keycode = 16'h0050;
        step();
        chk_all("lclamp.hop", 0, 335, 3, 1, 1);
        keycode = 16'h0000;
        set_plat(4'b0001, 4'b0001, 4'b0000);
        step();
        chk("lclamp.drift.x", 32'(FrogX), 0);
        chk("lclamp.drift.edge", 32'(edge_hit), 1);
        set_plat('0, '0, '0);
        step();
        chk("lclamp.quiet.edge", 32'(edge_hit), 0);

        // Asynchronous reset mid-hop and mid-drift.
        frogreset = 1'b1;
        step();
        frogreset = 1'b0;
        step();
        set_plat(4'b0001, 4'b0001, 4'b0001);
        keycode = 16'h004F;
        step();
        chk_all("mid.hop", 309, 335, 1, 1, 0);
        step();
        step();
        chk_all("mid.cnt2", 311, 335, 1, 1, 0);
        #2;
        Reset = 1'b0;
        #1;
        chk_all("async.reset", 296, 335, 0, 0, 0);
        set_in(16'h0000, 1'b0, 1'b1, 3'd3);
        set_plat('0, '0, '0);
        step();
        chk_all("async.hold", 296, 335, 0, 0, 0);
        Reset = 1'b1;
        model_reset();

        // Randomized frames against the model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 9);
            case (r)
                4: keycode = 16'h004F;
                5: keycode = 16'h0050;
                6: keycode = 16'h0051;
                7: keycode = 16'h0052;
                8: keycode = 16'h0029;
                9: ;
                default: keycode = 16'h0000;
            endcase
            frogreset = ($urandom_range(0, 49) == 0);
            move_en   = ($urandom_range(0, 9) != 0);
            lives     = ($urandom_range(0, 29) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            set_plat(NP'($urandom), NP'($urandom), NP'($urandom));
            model_frame();
            step();
            chk_all($sformatf("rand%0d", n), m_x, m_y, m_face, int'(m_hop), int'(m_edge));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
